// File: rtl/eop_pio_seq_pkg.sv
// Shared state encoding and PIO register map for the EOP PIO sequencer.
package eop_pio_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WR_MASK,
        ST_IDLE,
        ST_RD_SET,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_CLR,
        ST_PUSH
    } seq_state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/eop_evt_holdreg.sv
// Depth-1 valid/ready hold register; a push into an unaccepted event OR-merges and flags overflow.
module eop_evt_holdreg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_i,
    input  logic [1:0] cap_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [1:0] bits_o,
    output logic       overflow_o
);

    logic       valid_q, valid_d;
    logic [1:0] bits_q, bits_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        valid_d = valid_q;
        bits_d  = bits_q;
        ovf_d   = ovf_q;
        // A zero capture is a spurious read and is treated as no push at all.
        if (push_i && (cap_i != 2'b00)) begin
            if (!valid_q || ready_i) begin
                bits_d  = cap_i;
                valid_d = 1'b1;
            end else begin
                bits_d = bits_q | cap_i;
                ovf_d  = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            bits_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            bits_q  <= bits_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign bits_o     = bits_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/eop_pio_irq_sequencer.sv
// Avalon-MM master that programs the EOP PIO irq mask and services its edge-capture irq in hardware.
//  state    | meaning
//  INIT     | first cycle out of reset
//  WR_MASK  | write mask register to addr2
//  IDLE     | wait for mask update or enabled irq
//  RD_SET   | present addr3
//  RD_WAIT  | PIO registers read data
//  RD_CAP   | capture edge bits
//  CLR      | write addr3 to clear edge capture
//  PUSH     | hand capture to the event hold register
module eop_pio_irq_sequencer
    import eop_pio_seq_pkg::*;
#(
    parameter logic [1:0]  MASK_INIT = 2'b11,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       cfg_mask,
    input  logic             cfg_mask_wr,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             pio_irq,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_bits,
    output logic [CNT_W-1:0] eop_count,
    output logic             evt_overflow,
    output logic             busy
);

    seq_state_e       state_q, state_d;
    logic [1:0]       mask_q, mask_d;
    logic             mask_pend_q, mask_pend_d;
    logic [1:0]       cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             wn_q, wn_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             unused_rd_bits;

    assign unused_rd_bits = ^m_readdata[31:2];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_WR_MASK;
            ST_WR_MASK: state_d = ST_IDLE;
            ST_IDLE: begin
                if (mask_pend_q)             state_d = ST_WR_MASK;
                else if (pio_irq && enable)  state_d = ST_RD_SET;
            end
            ST_RD_SET:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_RD_CAP;
            ST_RD_CAP:  state_d = ST_CLR;
            ST_CLR:     state_d = ST_PUSH;
            ST_PUSH:    state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // Bus outputs are decoded from the next state so the registers line up with the state they belong to.
    always_comb begin
        addr_d  = PIO_ADDR_DATA;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        wdata_d = 32'd0;
        case (state_d)
            ST_WR_MASK: begin
                addr_d  = PIO_ADDR_MASK;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = {30'd0, mask_q};
            end
            ST_RD_SET, ST_RD_WAIT, ST_RD_CAP: addr_d = PIO_ADDR_EDGE;
            ST_CLR: begin
                addr_d  = PIO_ADDR_EDGE;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                wdata_d = 32'd3;
            end
            default: ;
        endcase
    end

    always_comb begin
        mask_d      = mask_q;
        mask_pend_d = mask_pend_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        if (state_d == ST_WR_MASK) mask_pend_d = 1'b0;
        // A new request wins over the clear so a pulse during WR_MASK causes a rewrite.
        if (cfg_mask_wr) begin
            mask_d      = cfg_mask;
            mask_pend_d = 1'b1;
        end
        if (state_q == ST_RD_CAP) cap_d = m_readdata[1:0];
        if ((state_q == ST_PUSH) && cap_q[0]) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            mask_q      <= MASK_INIT;
            mask_pend_q <= 1'b0;
            cap_q       <= 2'b00;
            cnt_q       <= '0;
            addr_q      <= PIO_ADDR_DATA;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mask_pend_q <= mask_pend_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            wdata_q     <= wdata_d;
        end
    end

    eop_evt_holdreg u_holdreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (state_q == ST_PUSH),
        .cap_i      (cap_q),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .bits_o     (evt_bits),
        .overflow_o (evt_overflow)
    );

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = wdata_q;
    assign eop_count    = cnt_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
